// File: rtl/phase_bus_sequencer.sv
// Command sequencer/arbiter for the phase-bus engines: buffers decoded commands,
// activates one engine at a time with a timeout, and returns one response per command.
module phase_bus_sequencer #(
  parameter int CLOCK_FREQUENCY = 27000000,
  parameter int TIMEOUT_CYCLES  = 2700,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_opcode,
  input  logic [1:0]  cmd_type,
  input  logic [31:0] cmd_params,
  output logic        write4_active,
  output logic        read4_active,
  output logic        adc4_active,
  input  logic        write4_complete,
  input  logic        read4_complete,
  input  logic        adc4_complete,
  output logic [31:0] param_data,
  output logic [1:0]  CommandType,
  input  logic [31:0] eng_resp_bytes,
  input  logic [3:0]  eng_resp_count,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_status,
  output logic [31:0] rsp_bytes,
  output logic [3:0]  rsp_count,
  output logic        busy,
  output logic [7:0]  timeout_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW:0]   FIFO_FULL  = (AW+1)'(FIFO_DEPTH);

  if (CLOCK_FREQUENCY <= 0 || TIMEOUT_CYCLES < 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("phase_bus_sequencer: illegal parameter set");
  end

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_DONE, S_RELEASE, S_RESPOND} state_t;

  state_t state_q, state_d;

  // Command FIFO: {opcode, type, params}
  logic [35:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          push, pop;

  logic [35:0]   cmd_q;
  logic [1:0]    cmd_op;
  logic [2:0]    active_q;
  logic [TW-1:0] timer_q;
  logic [1:0]    rel_cnt_q;
  logic [3:0]    complete_vec;
  logic          complete_sel;
  logic          timer_done;

  assign cmd_ready    = (fifo_cnt != FIFO_FULL);
  assign push         = cmd_valid && cmd_ready;
  assign pop          = (state_q == S_IDLE) && (fifo_cnt != '0);
  assign busy         = (state_q != S_IDLE) || (fifo_cnt != '0);
  assign cmd_op       = cmd_q[35:34];
  assign complete_vec = {1'b0, adc4_complete, read4_complete, write4_complete};
  assign complete_sel = complete_vec[cmd_op];
  assign timer_done   = (timer_q == TIMER_LAST);

  assign write4_active = active_q[0];
  assign read4_active  = active_q[1];
  assign adc4_active   = active_q[2];

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= {cmd_opcode, cmd_type, cmd_params};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      fifo_cnt <= fifo_cnt + (AW+1)'(1);
      else if (!push && pop) fifo_cnt <= fifo_cnt - (AW+1)'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (fifo_cnt != '0) state_d = S_ISSUE;
      S_ISSUE:     state_d = (cmd_op == 2'd3) ? S_RESPOND : S_WAIT_DONE;
      S_WAIT_DONE: if (complete_sel || timer_done) state_d = S_RELEASE;
      // Give the engine up to 4 cycles to drop complete before it can be re-armed
      S_RELEASE:   if (!complete_sel || rel_cnt_q == 2'd3) state_d = S_RESPOND;
      S_RESPOND:   if (rsp_valid && rsp_ready) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cmd_q         <= '0;
      active_q      <= '0;
      timer_q       <= '0;
      rel_cnt_q     <= '0;
      param_data    <= '0;
      CommandType   <= '0;
      rsp_valid     <= 1'b0;
      rsp_status    <= '0;
      rsp_bytes     <= '0;
      rsp_count     <= '0;
      timeout_count <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (pop) cmd_q <= fifo_mem[rd_ptr];
        S_ISSUE: begin
          param_data  <= cmd_q[31:0];
          CommandType <= cmd_q[33:32];
          timer_q     <= '0;
          if (cmd_op == 2'd3) begin
            rsp_status <= 2'd2;
            rsp_bytes  <= '0;
            rsp_count  <= '0;
          end else begin
            active_q <= 3'b001 << cmd_op;
          end
        end
        S_WAIT_DONE: begin
          timer_q   <= timer_q + TW'(1);
          rel_cnt_q <= '0;
          // Completion takes priority over a coincident timeout
          if (complete_sel) begin
            active_q   <= '0;
            rsp_status <= 2'd0;
            rsp_bytes  <= eng_resp_bytes;
            rsp_count  <= eng_resp_count;
          end else if (timer_done) begin
            active_q   <= '0;
            rsp_status <= 2'd1;
            rsp_bytes  <= '0;
            rsp_count  <= '0;
            if (timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
          end
        end
        S_RELEASE: rel_cnt_q <= rel_cnt_q + 2'd1;
        S_RESPOND: begin
          if (!rsp_valid)     rsp_valid <= 1'b1;
          else if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_phase_bus_sequencer.sv
// Randomized self-checking bench for phase_bus_sequencer: an engine model answers
// activations from a per-command behaviour queue; responses are checked in order.
module tb_phase_bus_sequencer;
  localparam int TIMEOUT = 2700;
  localparam int BOUND   = 10000;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_opcode, cmd_type;
  logic [31:0] cmd_params;
  logic        write4_active, read4_active, adc4_active;
  logic        write4_complete, read4_complete, adc4_complete;
  logic [31:0] param_data;
  logic [1:0]  CommandType;
  logic [31:0] eng_resp_bytes;
  logic [3:0]  eng_resp_count;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_status;
  logic [31:0] rsp_bytes;
  logic [3:0]  rsp_count;
  logic        busy;
  logic [7:0]  timeout_count;

  phase_bus_sequencer #(.CLOCK_FREQUENCY(27000000), .TIMEOUT_CYCLES(TIMEOUT), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_type(cmd_type), .cmd_params(cmd_params),
    .write4_active(write4_active), .read4_active(read4_active), .adc4_active(adc4_active),
    .write4_complete(write4_complete), .read4_complete(read4_complete),
    .adc4_complete(adc4_complete),
    .param_data(param_data), .CommandType(CommandType),
    .eng_resp_bytes(eng_resp_bytes), .eng_resp_count(eng_resp_count),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_bytes(rsp_bytes), .rsp_count(rsp_count),
    .busy(busy), .timeout_count(timeout_count)
  );

  always #5 clock = ~clock;

  // delay < 0 means the engine never completes
  typedef struct {
    logic [1:0]  op;
    logic [1:0]  typ;
    logic [31:0] params;
    int          delay;
    int          hold;
    logic [31:0] bytes;
    logic [3:0]  cnt;
  } cmd_t;

  cmd_t beh_q[$];
  cmd_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   tc_exp = 0;

  function automatic cmd_t mk(input logic [1:0] op, input logic [31:0] params, input int delay,
                              input int hold, input logic [31:0] bytes, input logic [3:0] cnt);
    cmd_t c;
    c.op = op; c.typ = 2'($urandom_range(0, 3)); c.params = params;
    c.delay = delay; c.hold = hold; c.bytes = bytes; c.cnt = cnt;
    return c;
  endfunction

  function automatic cmd_t rnd_cmd(input int hang_pct);
    logic [1:0] op;
    int dly;
    op  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    dly = ($urandom_range(0, 99) < hang_pct) ? -1 : $urandom_range(1, 20);
    return mk(op, $urandom, dly, $urandom_range(0, 6), $urandom, 4'($urandom_range(0, 15)));
  endfunction

  // ---------------- engine model ----------------
  cmd_t       eng_cur;
  logic       eng_have = 1'b0, eng_drv = 1'b0, prev_any = 1'b0;
  int         act_cyc = 0, hold_left = 0;
  logic [2:0] actv, sel_mask, noise;

  initial begin
    write4_complete = 1'b0; read4_complete = 1'b0; adc4_complete = 1'b0;
    eng_resp_bytes = '0; eng_resp_count = '0;
    forever begin
      @(negedge clock);
      actv = {adc4_active, read4_active, write4_active};
      if (!reset) begin
        {adc4_complete, read4_complete, write4_complete} = 3'b000;
        eng_have = 1'b0; eng_drv = 1'b0; prev_any = 1'b0; act_cyc = 0;
      end else begin
        checks++;
        if ($countones(actv) > 1) begin
          errors++; $display("FAIL one_hot: active=%b, required at most one bit set", actv);
        end
        if (actv != 3'b000 && !prev_any) begin
          checks++;
          if (beh_q.size() == 0) begin
            errors++; $display("FAIL unexpected_active: active=%b, required 000", actv);
            eng_have = 1'b0;
          end else begin
            eng_cur = beh_q.pop_front();
            eng_have = 1'b1;
            sel_mask = 3'b001 << eng_cur.op;
            if (actv !== sel_mask || CommandType !== eng_cur.typ) begin
              errors++;
              $display("FAIL issue: active=%b type=%0d, required active=%b type=%0d",
                       actv, CommandType, sel_mask, eng_cur.typ);
            end
          end
          act_cyc = 0;
        end
        if (actv != 3'b000 && eng_have) begin
          act_cyc++;
          checks++;
          if (param_data !== eng_cur.params) begin
            errors++; $display("FAIL param_data: got %h, required %h", param_data, eng_cur.params);
          end
          if (eng_cur.delay == act_cyc) begin
            eng_drv = 1'b1;
            eng_resp_bytes = eng_cur.bytes;
            eng_resp_count = eng_cur.cnt;
          end
        end
        if (actv == 3'b000 && prev_any && eng_have) begin
          checks++;
          if (act_cyc != ((eng_cur.delay < 0) ? TIMEOUT : eng_cur.delay)) begin
            errors++;
            $display("FAIL active_len: got %0d cycles, required %0d", act_cyc,
                     (eng_cur.delay < 0) ? TIMEOUT : eng_cur.delay);
          end
          hold_left = eng_cur.hold;
        end
        if (actv == 3'b000 && eng_drv) begin
          if (hold_left == 0) eng_drv = 1'b0;
          else hold_left--;
        end
        if (!eng_drv) begin
          eng_resp_bytes = $urandom;
          eng_resp_count = 4'($urandom_range(0, 15));
        end
        // Non-selected completes toggle randomly while an engine is active; they must be ignored
        noise = (actv != 3'b000 && eng_have) ? 3'($urandom_range(0, 7)) & ~sel_mask : 3'b000;
        if (eng_drv && eng_have) noise = noise | sel_mask;
        {adc4_complete, read4_complete, write4_complete} = noise;
        prev_any = (actv != 3'b000);
      end
    end
  end

  // ---------------- stimulus / response tasks ----------------
  task automatic send(input cmd_t c);
    int w = 0;
    cmd_valid = 1'b1; cmd_opcode = c.op; cmd_type = c.typ; cmd_params = c.params;
    while (cmd_ready !== 1'b1 && w < BOUND) begin @(negedge clock); w++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL send_accept: cmd_ready=%b, required 1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    exp_q.push_back(c);
    if (c.op != 2'd3) beh_q.push_back(c);
    if (c.op != 2'd3 && c.delay < 0 && tc_exp < 255) tc_exp++;
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic collect(input int n, input int first_stall);
    for (int i = 0; i < n; i++) begin
      int w = 0;
      int stall;
      cmd_t e;
      logic [1:0]  es;
      logic [31:0] eb;
      logic [3:0]  ec;
      while (rsp_valid !== 1'b1 && w < BOUND) begin @(negedge clock); w++; end
      checks++;
      if (rsp_valid !== 1'b1 || exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_wait: rsp_valid=%b expected_entries=%0d, required valid=1 with entry",
                 rsp_valid, exp_q.size());
        return;
      end
      e  = exp_q.pop_front();
      es = (e.op == 2'd3) ? 2'd2 : ((e.delay < 0) ? 2'd1 : 2'd0);
      eb = (es == 2'd0) ? e.bytes : 32'h0;
      ec = (es == 2'd0) ? e.cnt : 4'h0;
      stall = (i == 0) ? first_stall : $urandom_range(0, 3);
      for (int s = 0; s <= stall; s++) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_status !== es || rsp_bytes !== eb || rsp_count !== ec) begin
          errors++;
          $display("FAIL rsp_fields[%0d]: valid=%b status=%0d bytes=%h count=%0d, required valid=1 status=%0d bytes=%h count=%0d",
                   i, rsp_valid, rsp_status, rsp_bytes, rsp_count, es, eb, ec);
        end
        if (s == stall) rsp_ready = 1'b1;
        @(negedge clock);
      end
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++; $display("FAIL rsp_drop: rsp_valid=%b after handshake, required 0", rsp_valid);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; cmd_valid = 1'b0; cmd_opcode = '0; cmd_type = '0; cmd_params = '0;
    rsp_ready = 1'b0;
    #3;
    checks++;
    if ({write4_active, read4_active, adc4_active, rsp_valid} !== 4'b0 || param_data !== '0 ||
        CommandType !== '0 || rsp_status !== '0 || rsp_bytes !== '0 || rsp_count !== '0 ||
        timeout_count !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: act=%b%b%b rsp_valid=%b param=%h type=%0d st=%0d bytes=%h cnt=%0d tc=%0d busy=%b, required all 0",
               write4_active, read4_active, adc4_active, rsp_valid, param_data, CommandType,
               rsp_status, rsp_bytes, rsp_count, timeout_count, busy);
    end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_release: cmd_ready=%b busy=%b, required 1 and 0", cmd_ready, busy);
    end
  endtask

  task automatic test_single_write();
    send(mk(2'd0, 32'h44332211, 5, 1, $urandom, 4'($urandom_range(0, 15))));
    @(negedge clock);
    checks++;
    if (write4_active !== 1'b0) begin
      errors++; $display("FAIL latency_pop: write4_active=%b one cycle after push, required 0", write4_active);
    end
    @(negedge clock);
    checks++;
    if (write4_active !== 1'b1 || param_data !== 32'h44332211) begin
      errors++;
      $display("FAIL latency_active: write4_active=%b param=%h two cycles after push, required 1 and 44332211",
               write4_active, param_data);
    end
    collect(1, 0);
  endtask

  task automatic test_read_capture();
    send(mk(2'd1, $urandom, 7, 2, 32'hDEADBEEF, 4'd4));
    collect(1, 2);
  endtask

  task automatic test_timeout();
    send(mk(2'd2, $urandom, -1, 0, 32'h0, 4'h0));
    collect(1, 1);
    checks++;
    if (timeout_count !== 8'd1) begin
      errors++; $display("FAIL timeout_count: got %0d, required 1", timeout_count);
    end
    send(mk(2'd2, $urandom, 3, 0, 32'hA5A50F0F, 4'd2));
    collect(1, 0);
  endtask

  task automatic test_reserved();
    send(mk(2'd3, $urandom, 1, 0, 32'h0, 4'h0));
    @(negedge clock);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reserved_early1: rsp_valid=%b, required 0", rsp_valid);
    end
    @(negedge clock);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reserved_early2: rsp_valid=%b, required 0", rsp_valid);
    end
    @(negedge clock);
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL reserved_latency: rsp_valid=%b two cycles after pop, required 1", rsp_valid);
    end
    collect(1, 0);
  endtask

  task automatic test_backpressure();
    send(mk(2'd0, $urandom, 60, 1, $urandom, 4'd3));
    for (int i = 0; i < 4; i++) send(rnd_cmd(0));
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL fifo_full: cmd_ready=%b busy=%b, required 0 and 1", cmd_ready, busy);
    end
    fork
      send(rnd_cmd(0));
      collect(6, 10);
    join
  endtask

  task automatic test_random();
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          send(rnd_cmd(5));
          repeat ($urandom_range(0, 3)) @(negedge clock);
        end
      end
      collect(30, $urandom_range(0, 5));
    join
    checks++;
    if (timeout_count !== 8'(tc_exp)) begin
      errors++; $display("FAIL timeout_total: got %0d, required %0d", timeout_count, tc_exp);
    end
  endtask

  task automatic test_reset_mid();
    int w = 0;
    send(mk(2'd1, $urandom, -1, 0, 32'h0, 4'h0));
    while (read4_active !== 1'b1 && w < 20) begin @(negedge clock); w++; end
    checks++;
    if (read4_active !== 1'b1) begin
      errors++; $display("FAIL mid_active: read4_active=%b, required 1", read4_active);
    end
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (read4_active !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: read4_active=%b rsp_valid=%b, required 0 and 0", read4_active, rsp_valid);
    end
    beh_q.delete();
    exp_q.delete();
    tc_exp = 0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1 || timeout_count !== 8'd0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: busy=%b cmd_ready=%b tc=%0d rsp_valid=%b, required 0 1 0 0",
               busy, cmd_ready, timeout_count, rsp_valid);
    end
    send(mk(2'd1, $urandom, 4, 3, 32'h12345678, 4'd4));
    collect(1, 0);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_capture();
    test_timeout();
    test_reserved();
    test_backpressure();
    test_random();
    test_reset_mid();
    repeat (5) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/phase_bus_sequencer.md
# phase_bus_sequencer

Command sequencer and arbiter for the phase-bus access engines (write4, read4, adc4). It sits between the UART command decoder and the engines and buffers decoded commands in a small FIFO. It activates exactly one engine at a time using the level active/complete handshake, bounds each command with a timeout, and returns one response record per command to the UART response path.

## Interface
- CLOCK_FREQUENCY, 27000000, system clock in Hz (documentation only)
- TIMEOUT_CYCLES, 2700, max cycles an engine may stay active (100 µs at 27 MHz); must be ≥ 2
- FIFO_DEPTH, 4, command FIFO entries; power of two, ≥ 2

- clock  in  1  system clock; sole clock of the block
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  decoder presents a command
- cmd_ready  out  1  FIFO can accept; equals !fifo_full
- cmd_opcode  in  2  0 = write4, 1 = read4, 2 = adc4, 3 = reserved
- cmd_type  in  2  forwarded as CommandType
- cmd_params  in  32  four parameter bytes; byte 0 in [7:0]
- write4_active, read4_active, adc4_active  out  1 each  engine enables; at most one high
- write4_complete, read4_complete, adc4_complete  in  1 each  engine done flags
- param_data  out  32  parameters of the issued command, stable while any active is high
- CommandType  out  2  type of the issued command
- eng_resp_bytes  in  32  engine response bytes
- eng_resp_count  in  4  engine response byte count
- rsp_valid  out  1  response record available
- rsp_ready  in  1  UART path accepts the record
- rsp_status  out  2  0 = OK, 1 = timeout, 2 = bad opcode
- rsp_bytes  out  32  captured response bytes
- rsp_count  out  4  captured byte count
- busy  out  1  high in any state other than IDLE, or while the FIFO is non-empty
- timeout_count  out  8  saturating count of timeouts

## Operation
- FIFO
  - Entry format is {opcode, type, params} (36 bits).
  - Push on cmd_valid && cmd_ready.
  - Pop when IDLE and non-empty.
  - Simultaneous push and pop leaves occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH; a separate occupancy counter distinguishes full from empty.
- States
  - IDLE: if FIFO non-empty, pop the entry into the command register and go to ISSUE.
  - ISSUE: load param_data and CommandType; clear the timer.
    - Opcode 3: no active is raised; set status = 2, rsp_bytes = 0, rsp_count = 0; go to RESPOND.
    - Otherwise: raise the selected engine's active and go to WAIT_DONE.
  - WAIT_DONE: timer increments each cycle.
    - Selected complete = 1: capture eng_resp_bytes and eng_resp_count, set status = 0, drop active, go to RELEASE.
    - Timer = TIMEOUT_CYCLES−1 with no complete: drop active, set status = 1, zero bytes and count, increment timeout_count (saturating at 255), go to RELEASE.
    - Complete wins if both conditions hold in the same cycle.
  - RELEASE: wait until the selected complete = 0, or 4 cycles have elapsed, then go to RESPOND. This guarantees the engine has returned to idle before the next activation.
  - RESPOND: hold rsp_valid and all rsp_* fields stable; on rsp_ready go to IDLE.
- Complete inputs of non-selected engines are ignored.
- Reset (low, asynchronous):
  - all active outputs = 0, rsp_valid = 0, FIFO empty, state = IDLE
  - param_data, CommandType, rsp_* and timeout_count = 0
  - cmd_ready = 1 from the first clock after reset is released

## Timing
- Command latency: push at cycle N with an empty FIFO and IDLE state → pop at N+1 → active high at N+2.
- Engine completion: complete seen at cycle M → active low at M+1 → RELEASE.
- Response latency: rsp_valid rises 1 cycle after RELEASE exits.
- Back-to-back commands: minimum 2 cycles from rsp_valid && rsp_ready to the next active rising.
- Registered outputs: all outputs are registered except cmd_ready and busy.
- Timeout timer:
  - width ⌈log2(TIMEOUT_CYCLES)⌉
  - counts 0 … TIMEOUT_CYCLES−1 with active high, so active is high for exactly TIMEOUT_CYCLES cycles on timeout
- One-hot rule: an active output may only rise in ISSUE and may only fall on the WAIT_DONE exit edge.

## Test plan
- Single write4:
  - Stimulus: opcode 0, params 0x44332211; model asserts write4_complete 5 cycles after active and releases it 1 cycle after active falls.
  - Required: param_data = 0x44332211 while active; one response with status 0; rsp_count as driven.
- Read4 response capture:
  - Stimulus: model drives eng_resp_bytes = 0xDEADBEEF, count 4, together with complete.
  - Required: rsp_bytes = 0xDEADBEEF, rsp_count = 4, status 0.
- Timeout:
  - Stimulus: adc4 command; complete never asserted.
  - Required: adc4_active high exactly 2700 cycles; status 1, rsp_bytes = 0, rsp_count = 0; timeout_count = 1; next command then issues normally.
- Reserved opcode:
  - Stimulus: opcode 3.
  - Required: no active ever rises; status 2 response 2 cycles after pop.
- FIFO backpressure:
  - Stimulus: 6 commands offered back-to-back while engine 0 hangs waiting on complete.
  - Required: cmd_ready drops after 4 accepted while the first is executing; all accepted commands execute in order; rsp_ready held low 10 cycles keeps rsp_* stable.
- Reset mid-command:
  - Stimulus: reset low during WAIT_DONE.
  - Required: active falls asynchronously; rsp_valid = 0; FIFO empty; busy = 0 after reset is released.
